// File: rtl/shop_db_ctrl.sv
// shop_db_ctrl: word-serial shop database controller.
// A user table (slot 0 is the fixed admin account) and an item table are
// driven by a command/name/password/quantity word stream. Every accepted word
// is answered by one response code on the following cycle.
//
// Handshake: i_rdy high in a cycle means i_a carries one word that is consumed
// at that rising edge (no backpressure). o_vld pulses for exactly one cycle,
// the cycle after acceptance; o_a keeps the last response code until the next.
//
// Optional feature: define SHOP_DB_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYC idle cycles outside CMD with response Timeout.
// o_dbg_state exposes the FSM state (0 CMD, 1 USER, 2 PASS, 3 ITEM, 4 QTY).
module shop_db_ctrl #(
  parameter int                DATA_W      = 24,
  parameter int                MAX_USERS   = 5,
  parameter int                MAX_ITEMS   = 8,
  parameter int                STOCK_W     = 8,
  parameter logic [DATA_W-1:0] ADMIN_NAME  = "Adm",
  parameter logic [DATA_W-1:0] ADMIN_PASS  = 24'h000001,
  parameter int                TIMEOUT_CYC = 1000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rdy,
  input  logic [DATA_W-1:0] i_a,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_a,
  output logic [2:0]        o_dbg_state
);

  localparam int UIDX_W = (MAX_USERS > 1) ? $clog2(MAX_USERS) : 1;
  localparam int IIDX_W = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_USER = 3'd1,
    S_PASS = 3'd2,
    S_ITEM = 3'd3,
    S_QTY  = 3'd4
  } state_e;

  localparam logic [2:0] C_LOGIN   = 3'd1;
  localparam logic [2:0] C_LOGOUT  = 3'd2;
  localparam logic [2:0] C_ADDUSR  = 3'd3;
  localparam logic [2:0] C_DELUSR  = 3'd4;
  localparam logic [2:0] C_ADDITEM = 3'd5;
  localparam logic [2:0] C_DELITEM = 3'd6;
  localparam logic [2:0] C_BUY     = 3'd7;

  localparam logic [3:0] R_OK         = 4'd1;
  localparam logic [3:0] R_INVALCMD   = 4'd2;
  localparam logic [3:0] R_INVALPERM  = 4'd3;
  localparam logic [3:0] R_USRNAME    = 4'd4;
  localparam logic [3:0] R_PASSWD     = 4'd5;
  localparam logic [3:0] R_USRUNKNWN  = 4'd6;
  localparam logic [3:0] R_USRTAKEN   = 4'd7;
  localparam logic [3:0] R_NODELADMN  = 4'd8;
  localparam logic [3:0] R_BADPASS    = 4'd9;
  localparam logic [3:0] R_ITEM       = 4'd10;
  localparam logic [3:0] R_QTY        = 4'd11;
  localparam logic [3:0] R_ITEMUNKNWN = 4'd12;
  localparam logic [3:0] R_FULL       = 4'd13;
  localparam logic [3:0] R_NOSTOCK    = 4'd14;
  localparam logic [3:0] R_TIMEOUT    = 4'd15;

  state_e              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic                sess_vld_q, sess_vld_d;
  logic [UIDX_W-1:0]   sess_idx_q, sess_idx_d;
  logic [UIDX_W-1:0]   usr_idx_q, usr_idx_d;
  logic [IIDX_W-1:0]   itm_idx_q, itm_idx_d;
  logic                itm_new_q, itm_new_d;
  logic [DATA_W-1:0]   name_q, name_d;
  logic                vld_q, vld_d;
  logic [3:0]          code_q, code_d;

  logic [MAX_USERS-1:0] usr_vld_q, usr_vld_d;
  logic [DATA_W-1:0]    usr_name_q [MAX_USERS];
  logic [DATA_W-1:0]    usr_name_d [MAX_USERS];
  logic [DATA_W-1:0]    usr_pass_q [MAX_USERS];
  logic [DATA_W-1:0]    usr_pass_d [MAX_USERS];
  logic [MAX_ITEMS-1:0] itm_vld_q, itm_vld_d;
  logic [DATA_W-1:0]    itm_name_q [MAX_ITEMS];
  logic [DATA_W-1:0]    itm_name_d [MAX_ITEMS];
  logic [STOCK_W-1:0]   itm_stock_q [MAX_ITEMS];
  logic [STOCK_W-1:0]   itm_stock_d [MAX_ITEMS];

  logic                usr_hit, usr_free;
  logic [UIDX_W-1:0]   usr_hit_idx, usr_free_idx;
  logic                itm_hit, itm_free;
  logic [IIDX_W-1:0]   itm_hit_idx, itm_free_idx;
  logic                is_admin;
  logic [STOCK_W-1:0]  qty;
  logic [STOCK_W-1:0]  stock_base;
  logic [STOCK_W:0]    stock_sum;

`ifdef SHOP_DB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  // Parameter only matters when the timeout is compiled in.
  logic [31:0] tmo_unused;
  assign tmo_unused = 32'(TIMEOUT_CYC);
`endif

  assign o_vld       = vld_q;
  assign o_a         = DATA_W'(code_q);
  assign o_dbg_state = state_q;
  assign is_admin    = sess_vld_q && (sess_idx_q == '0);
  assign qty         = i_a[STOCK_W-1:0];

  // Same-cycle table lookups: name match and free slot, lowest index wins.
  always_comb begin
    usr_hit = 1'b0; usr_hit_idx = '0; usr_free = 1'b0; usr_free_idx = '0;
    itm_hit = 1'b0; itm_hit_idx = '0; itm_free = 1'b0; itm_free_idx = '0;
    for (int i = MAX_USERS - 1; i >= 0; i--) begin
      if (usr_vld_q[i] && (usr_name_q[i] == i_a)) begin
        usr_hit = 1'b1; usr_hit_idx = UIDX_W'(i);
      end
      if (!usr_vld_q[i]) begin
        usr_free = 1'b1; usr_free_idx = UIDX_W'(i);
      end
    end
    for (int i = MAX_ITEMS - 1; i >= 0; i--) begin
      if (itm_vld_q[i] && (itm_name_q[i] == i_a)) begin
        itm_hit = 1'b1; itm_hit_idx = IIDX_W'(i);
      end
      if (!itm_vld_q[i]) begin
        itm_free = 1'b1; itm_free_idx = IIDX_W'(i);
      end
    end
  end

  // Next-state, response and table-update logic for one accepted word.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    sess_vld_d  = sess_vld_q;
    sess_idx_d  = sess_idx_q;
    usr_idx_d   = usr_idx_q;
    itm_idx_d   = itm_idx_q;
    itm_new_d   = itm_new_q;
    name_d      = name_q;
    vld_d       = 1'b0;
    code_d      = code_q;
    usr_vld_d   = usr_vld_q;
    usr_name_d  = usr_name_q;
    usr_pass_d  = usr_pass_q;
    itm_vld_d   = itm_vld_q;
    itm_name_d  = itm_name_q;
    itm_stock_d = itm_stock_q;
    stock_base  = itm_new_q ? '0 : itm_stock_q[itm_idx_q];
    stock_sum   = {1'b0, stock_base} + {1'b0, qty};
`ifdef SHOP_DB_TIMEOUT_EN
    tmo_d       = '0;
`endif
    if (i_rdy) begin
      vld_d   = 1'b1;
      state_d = S_CMD;
      case (state_q)
        S_CMD: begin
          cmd_d = i_a[2:0];
          case (i_a[2:0])
            C_LOGIN: begin
              sess_vld_d = 1'b0;
              state_d    = S_USER;
              code_d     = R_USRNAME;
            end
            C_LOGOUT: begin
              if (sess_vld_q) begin
                sess_vld_d = 1'b0;
                code_d     = R_OK;
              end else begin
                code_d = R_INVALPERM;
              end
            end
            C_ADDUSR, C_DELUSR: begin
              if (is_admin) begin
                state_d = S_USER;
                code_d  = R_USRNAME;
              end else begin
                code_d = R_INVALPERM;
              end
            end
            C_ADDITEM, C_DELITEM: begin
              if (is_admin) begin
                state_d = S_ITEM;
                code_d  = R_ITEM;
              end else begin
                code_d = R_INVALPERM;
              end
            end
            C_BUY: begin
              if (sess_vld_q) begin
                state_d = S_ITEM;
                code_d  = R_ITEM;
              end else begin
                code_d = R_INVALPERM;
              end
            end
            default: code_d = R_INVALCMD;
          endcase
        end
        S_USER: begin
          case (cmd_q)
            C_LOGIN: begin
              if (!usr_hit) begin
                code_d = R_USRUNKNWN;
              end else begin
                usr_idx_d = usr_hit_idx;
                state_d   = S_PASS;
                code_d    = R_PASSWD;
              end
            end
            C_ADDUSR: begin
              if (usr_hit) begin
                code_d = R_USRTAKEN;
              end else if (!usr_free) begin
                code_d = R_FULL;
              end else begin
                usr_idx_d = usr_free_idx;
                name_d    = i_a;
                state_d   = S_PASS;
                code_d    = R_PASSWD;
              end
            end
            C_DELUSR: begin
              if (!usr_hit) begin
                code_d = R_USRUNKNWN;
              end else if (i_a == ADMIN_NAME) begin
                code_d = R_NODELADMN;
              end else begin
                usr_vld_d[usr_hit_idx] = 1'b0;
                code_d                 = R_OK;
              end
            end
            default: code_d = R_INVALCMD;
          endcase
        end
        S_PASS: begin
          if (cmd_q == C_ADDUSR) begin
            usr_vld_d[usr_idx_q]  = 1'b1;
            usr_name_d[usr_idx_q] = name_q;
            usr_pass_d[usr_idx_q] = i_a;
            code_d                = R_OK;
          end else if (usr_pass_q[usr_idx_q] == i_a) begin
            sess_vld_d = 1'b1;
            sess_idx_d = usr_idx_q;
            code_d     = R_OK;
          end else begin
            code_d = R_BADPASS;
          end
        end
        S_ITEM: begin
          case (cmd_q)
            C_ADDITEM: begin
              // A new item is only written once its quantity arrives, so an
              // abandoned transaction leaves the table untouched.
              if (itm_hit) begin
                itm_idx_d = itm_hit_idx;
                itm_new_d = 1'b0;
                state_d   = S_QTY;
                code_d    = R_QTY;
              end else if (itm_free) begin
                itm_idx_d = itm_free_idx;
                itm_new_d = 1'b1;
                name_d    = i_a;
                state_d   = S_QTY;
                code_d    = R_QTY;
              end else begin
                code_d = R_FULL;
              end
            end
            C_DELITEM: begin
              if (!itm_hit) begin
                code_d = R_ITEMUNKNWN;
              end else begin
                itm_vld_d[itm_hit_idx] = 1'b0;
                code_d                 = R_OK;
              end
            end
            C_BUY: begin
              if (!itm_hit) begin
                code_d = R_ITEMUNKNWN;
              end else begin
                itm_idx_d = itm_hit_idx;
                itm_new_d = 1'b0;
                state_d   = S_QTY;
                code_d    = R_QTY;
              end
            end
            default: code_d = R_INVALCMD;
          endcase
        end
        S_QTY: begin
          if (cmd_q == C_ADDITEM) begin
            itm_stock_d[itm_idx_q] = stock_sum[STOCK_W] ? '1 : stock_sum[STOCK_W-1:0];
            if (itm_new_q) begin
              itm_vld_d[itm_idx_q]  = 1'b1;
              itm_name_d[itm_idx_q] = name_q;
            end
            code_d = R_OK;
          end else if (qty <= itm_stock_q[itm_idx_q]) begin
            itm_stock_d[itm_idx_q] = itm_stock_q[itm_idx_q] - qty;
            code_d                 = R_OK;
          end else begin
            code_d = R_NOSTOCK;
          end
        end
        default: code_d = R_INVALCMD;
      endcase
    end
`ifdef SHOP_DB_TIMEOUT_EN
    else if (state_q != S_CMD) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d = S_CMD;
        vld_d   = 1'b1;
        code_d  = R_TIMEOUT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  // State, session, response and table registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_CMD;
      cmd_q      <= '0;
      sess_vld_q <= 1'b0;
      sess_idx_q <= '0;
      usr_idx_q  <= '0;
      itm_idx_q  <= '0;
      itm_new_q  <= 1'b0;
      name_q     <= '0;
      vld_q      <= 1'b0;
      code_q     <= '0;
      usr_vld_q  <= MAX_USERS'(1);
      itm_vld_q  <= '0;
      for (int i = 0; i < MAX_USERS; i++) begin
        usr_name_q[i] <= (i == 0) ? ADMIN_NAME : '0;
        usr_pass_q[i] <= (i == 0) ? ADMIN_PASS : '0;
      end
      for (int i = 0; i < MAX_ITEMS; i++) begin
        itm_name_q[i]  <= '0;
        itm_stock_q[i] <= '0;
      end
`ifdef SHOP_DB_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      sess_vld_q  <= sess_vld_d;
      sess_idx_q  <= sess_idx_d;
      usr_idx_q   <= usr_idx_d;
      itm_idx_q   <= itm_idx_d;
      itm_new_q   <= itm_new_d;
      name_q      <= name_d;
      vld_q       <= vld_d;
      code_q      <= code_d;
      usr_vld_q   <= usr_vld_d;
      usr_name_q  <= usr_name_d;
      usr_pass_q  <= usr_pass_d;
      itm_vld_q   <= itm_vld_d;
      itm_name_q  <= itm_name_d;
      itm_stock_q <= itm_stock_d;
`ifdef SHOP_DB_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_shop_db_ctrl.sv
// tb_shop_db_ctrl: directed bench for shop_db_ctrl with hand-computed
// response codes; words are driven on the falling edge and responses are
// sampled one falling edge later.
module tb_shop_db_ctrl;

  localparam logic [23:0] OK = 1, INVALCMD = 2, INVALPERM = 3, USRNAME = 4,
    PASSWD = 5, USRUNKNWN = 6, USRTAKEN = 7, NODELADMN = 8, BADPASS = 9,
    ITEMQ = 10, QTYQ = 11, ITEMUNKNWN = 12, FULL = 13, NOSTOCK = 14,
    TIMEOUT = 15;

  localparam logic [23:0] LOGIN = 1, LOGOUT = 2, ADDUSR = 3, DELUSR = 4,
    ADDITEM = 5, DELITEM = 6, BUY = 7;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_rdy = 1'b0;
  logic [23:0] i_a = '0;
  logic        o_vld;
  logic [23:0] o_a;
  logic [2:0]  o_dbg_state;

  int total = 0;
  int bad   = 0;

  shop_db_ctrl #(
    .DATA_W     (24),
    .MAX_USERS  (5),
    .MAX_ITEMS  (8),
    .STOCK_W    (8),
    .ADMIN_NAME ("Adm"),
    .ADMIN_PASS (24'h000001),
    .TIMEOUT_CYC(16)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rdy      (i_rdy),
    .i_a        (i_a),
    .o_vld      (o_vld),
    .o_a        (o_a),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and safety limit.
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one word (called at a falling edge) and check its response.
  task automatic send(input logic [23:0] w, input logic [23:0] exp, input string tag);
    i_rdy = 1'b1;
    i_a   = w;
    @(negedge i_clk);
    i_rdy = 1'b0;
    i_a   = '0;
    chk({tag, " vld"}, 32'(o_vld), 32'd1);
    chk({tag, " code"}, 32'(o_a), 32'(exp));
  endtask

  // One idle cycle: no response pulse, last code held.
  task automatic idle_chk(input logic [23:0] held, input string tag);
    @(negedge i_clk);
    chk({tag, " no vld"}, 32'(o_vld), 32'd0);
    chk({tag, " held"}, 32'(o_a), 32'(held));
  endtask

  initial begin
    // Reset with i_rdy high: must be ignored.
    i_reset = 1'b1; i_rdy = 1'b1; i_a = LOGIN;
    repeat (3) @(negedge i_clk);
    chk("rst vld", 32'(o_vld), 32'd0);
    chk("rst oa", 32'(o_a), 32'd0);
    chk("rst state", 32'(o_dbg_state), 32'd0);
    i_reset = 1'b0; i_rdy = 1'b0; i_a = '0;
    idle_chk(24'd0, "post rst");

    // Admin login with single pulses.
    send(LOGIN, USRNAME, "login cmd");
    chk("state user", 32'(o_dbg_state), 32'd1);
    send("Adm", PASSWD, "login name");
    chk("state pass", 32'(o_dbg_state), 32'd2);
    send(24'h000001, OK, "login pass");
    chk("state cmd", 32'(o_dbg_state), 32'd0);
    idle_chk(OK, "pulse");

    // Fill the user table.
    send(ADDUSR, USRNAME, "add1"); send("Bob", PASSWD, "add1 n"); send(24'h22, OK, "add1 p");
    send(ADDUSR, USRNAME, "add2"); send("Cat", PASSWD, "add2 n"); send(24'h33, OK, "add2 p");
    send(ADDUSR, USRNAME, "add3"); send("Dan", PASSWD, "add3 n"); send(24'h44, OK, "add3 p");
    send(ADDUSR, USRNAME, "add4"); send("Eve", PASSWD, "add4 n"); send(24'h55, OK, "add4 p");
    send(ADDUSR, USRNAME, "add5"); send("Fay", FULL, "add5 full");
    send(DELUSR, USRNAME, "del adm"); send("Adm", NODELADMN, "del adm n");
    send(ADDUSR, USRNAME, "add dup"); send("Bob", USRTAKEN, "add dup n");
    send(DELUSR, USRNAME, "del eve"); send("Eve", OK, "del eve n");
    send(ADDUSR, USRNAME, "reuse"); send("Fay", PASSWD, "reuse n"); send(24'h66, OK, "reuse p");
    send(DELUSR, USRNAME, "del zed"); send("Zed", USRUNKNWN, "del zed n");

    // Items: saturation, upper-bit quantity masking, bad command.
    send(ADDITEM, ITEMQ, "pen add"); send("Pen", QTYQ, "pen n");
    chk("state qty", 32'(o_dbg_state), 32'd4);
    send(24'd250, OK, "pen 250");
    send(ADDITEM, ITEMQ, "pen add2"); send("Pen", QTYQ, "pen n2"); send(24'd10, OK, "pen 10");
    send(24'd0, INVALCMD, "cmd0");
    send(DELITEM, ITEMQ, "del ink"); send("Ink", ITEMUNKNWN, "del ink n");
    send(ADDITEM, ITEMQ, "ink add"); send("Ink", QTYQ, "ink n"); send(24'h000103, OK, "ink 3");
    send(LOGOUT, OK, "logout");
    send(BUY, INVALPERM, "buy nosess");
    send(LOGOUT, INVALPERM, "logout nosess");

    // Ordinary user.
    send(LOGIN, USRNAME, "bob li"); send("Bob", PASSWD, "bob n"); send(24'h23, BADPASS, "bob badp");
    send(LOGIN, USRNAME, "bob li2"); send("Bob", PASSWD, "bob n2"); send(24'h22, OK, "bob p");
    send(ADDITEM, INVALPERM, "bob additem");
    send(DELUSR, INVALPERM, "bob delusr");
    send(BUY, ITEMQ, "buy256"); send("Pen", QTYQ, "buy256 n"); send(24'd256, OK, "buy256 q");
    send(BUY, ITEMQ, "buy200"); send("Pen", QTYQ, "buy200 n"); send(24'd200, OK, "buy200 q");
    send(BUY, ITEMQ, "buy56"); send("Pen", QTYQ, "buy56 n"); send(24'd56, NOSTOCK, "buy56 q");
    send(BUY, ITEMQ, "ink4"); send("Ink", QTYQ, "ink4 n"); send(24'd4, NOSTOCK, "ink4 q");
    send(BUY, ITEMQ, "ink3"); send("Ink", QTYQ, "ink3 n"); send(24'd3, OK, "ink3 q");
    send(BUY, ITEMQ, "ink1"); send("Ink", QTYQ, "ink1 n"); send(24'd1, NOSTOCK, "ink1 q");
    send(BUY, ITEMQ, "mug"); send("Mug", ITEMUNKNWN, "mug n");
    send(LOGIN, USRNAME, "zed li"); send("Zed", USRUNKNWN, "zed n");
    send(BUY, INVALPERM, "buy after zed");
    send(LOGIN, USRNAME, "fay li"); send("Fay", PASSWD, "fay n"); send(24'h66, OK, "fay p");

`ifdef SHOP_DB_TIMEOUT_EN
    // 16 idle cycles abort, 15 do not.
    send(LOGIN, USRNAME, "tmo li");
    repeat (15) @(negedge i_clk);
    chk("tmo 15 vld", 32'(o_vld), 32'd0);
    chk("tmo 15 state", 32'(o_dbg_state), 32'd1);
    @(negedge i_clk);
    chk("tmo 16 vld", 32'(o_vld), 32'd1);
    chk("tmo 16 code", 32'(o_a), 32'(TIMEOUT));
    chk("tmo 16 state", 32'(o_dbg_state), 32'd0);
    send(LOGIN, USRNAME, "tmo li2");
    repeat (15) @(negedge i_clk);
    chk("tmo15 vld", 32'(o_vld), 32'd0);
    send("Fay", PASSWD, "tmo15 n"); send(24'h66, OK, "tmo15 p");
`else
    // Without the timeout the FSM waits indefinitely.
    send(LOGIN, USRNAME, "wait li");
    repeat (20) @(negedge i_clk);
    chk("wait vld", 32'(o_vld), 32'd0);
    chk("wait state", 32'(o_dbg_state), 32'd1);
    send("Fay", PASSWD, "wait n"); send(24'h66, OK, "wait p");
`endif

    // Reset in QTY of Buy "Pen" 5.
    send(BUY, ITEMQ, "rb buy"); send("Pen", QTYQ, "rb n");
    i_reset = 1'b1; i_rdy = 1'b1; i_a = 24'd5;
    @(negedge i_clk);
    chk("rb vld", 32'(o_vld), 32'd0);
    chk("rb oa", 32'(o_a), 32'd0);
    chk("rb state", 32'(o_dbg_state), 32'd0);
    i_reset = 1'b0; i_rdy = 1'b0; i_a = '0;
    idle_chk(24'd0, "rb idle");
    send(BUY, INVALPERM, "rb nosess");
    send(LOGIN, USRNAME, "rb bob"); send("Bob", USRUNKNWN, "rb bob n");
    send(LOGIN, USRNAME, "rb fay"); send("Fay", USRUNKNWN, "rb fay n");
    send(LOGIN, USRNAME, "rb adm"); send("Adm", PASSWD, "rb adm n"); send(24'h1, OK, "rb adm p");
    send(BUY, ITEMQ, "rb pen"); send("Pen", ITEMUNKNWN, "rb pen n");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shop_db_ctrl.md
SHOP_DB_CTRL -- requirements
Module: shop_db_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 24: width of i_a and o_a, and of every username, password and item name.
REQ-002 SHALL have parameter MAX_USERS, default 5: user-table depth, admin included.
REQ-003 SHALL have parameter MAX_ITEMS, default 8: item-table depth.
REQ-004 SHALL have parameter STOCK_W, default 8: stock and quantity width.
REQ-005 SHALL have parameters ADMIN_NAME, default "Adm", and ADMIN_PASS, default 24'h000001: the slot-0 credentials.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 1000: inactivity limit in cycles (see Configuration).
REQ-007 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-008 i_reset  input  1  synchronous active-high reset.
REQ-009 i_rdy  input  1  i_a valid this cycle; each high cycle is one accepted word.
REQ-010 i_a  input  DATA_W  command code, name, password or quantity.
REQ-011 o_vld  output  1  one-cycle pulse: o_a holds a response.
REQ-012 o_a  output  DATA_W  response code, zero-extended.

Function
REQ-013 Response codes SHALL be: 1 Ok, 2 InvalCmd, 3 InvalPerm, 4 Usrname?, 5 Passwd?, 6 UsrUnknwn, 7 UsrTaken, 8 NoDelAdmn, 9 BadPass, 10 Item?, 11 Qty?, 12 ItemUnknwn, 13 Full, 14 NoStock, 15 Timeout.
REQ-014 Every accepted word SHALL produce exactly one response; o_vld is high the cycle after acceptance; o_a holds its value until the next response.
REQ-015 Command codes, taken from i_a[2:0] in state CMD, SHALL be: 1 Login, 2 Logout, 3 AddUsr, 4 DelUsr, 5 AddItem, 6 DelItem, 7 Buy; code 0 returns InvalCmd.
REQ-016 The FSM SHALL have states CMD, USER, PASS, ITEM and QTY; it returns to CMD after every terminal response (Ok or any error).
REQ-017 Permissions: Login is always allowed; AddUsr, DelUsr, AddItem and DelItem require the admin session; Buy and Logout require any session. A violation returns InvalPerm and stays in CMD.
REQ-018 Login SHALL clear the session, then go to USER with Usrname?. An unknown name returns UsrUnknwn. A known name goes to PASS with Passwd?; a matching password sets the session to that slot with Ok, a mismatch returns BadPass.
REQ-019 Logout SHALL clear the session and return Ok.
REQ-020 AddUsr SHALL go to USER with Usrname?. An existing name returns UsrTaken; no free slot returns Full; otherwise it goes to PASS with Passwd?, and the password word writes the lowest free slot with Ok.
REQ-021 DelUsr SHALL go to USER with Usrname?. An unknown name returns UsrUnknwn, ADMIN_NAME returns NoDelAdmn, otherwise the slot is freed with Ok.
REQ-022 AddItem SHALL go to ITEM with Item?. If the name exists it selects that slot; if not it allocates the lowest free slot with stock 0, or returns Full if none is free. Then QTY with Qty?; the quantity adds to stock, saturating at 2^STOCK_W-1, with Ok.
REQ-023 DelItem SHALL go to ITEM with Item?. An unknown item returns ItemUnknwn, otherwise the slot is freed with Ok.
REQ-024 Buy SHALL go to ITEM with Item?. An unknown item returns ItemUnknwn; a known item goes to QTY with Qty?. If qty <= stock, stock is reduced by qty with Ok; otherwise NoStock with stock unchanged. Qty 0 returns Ok with no change.
REQ-025 Quantities SHALL be taken from i_a[STOCK_W-1:0]; upper bits are ignored.
REQ-026 Name lookup SHALL be a full DATA_W compare over valid slots only, resolved within the cycle the word is accepted; the lowest matching index wins.
REQ-027 The slot freed by a delete SHALL be reusable by the next add.

Reset
REQ-028 While i_reset is high, on each clock edge: state = CMD, session = none, every table slot invalid except user slot 0 (ADMIN_NAME/ADMIN_PASS), o_vld = 0, o_a = 0, timeout counter = 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no table update and no response.
REQ-030 i_rdy asserted during a reset cycle SHALL be ignored.

Configuration
REQ-031 Macro SHOP_DB_TIMEOUT_EN defined: in USER, PASS, ITEM or QTY, TIMEOUT_CYC consecutive cycles without i_rdy SHALL abort to CMD with response Timeout, no table update and session unchanged; the counter clears on every accepted word and in CMD.
REQ-032 Macro undefined: no counter SHALL be present, and the FSM waits indefinitely in any state.

Verification
REQ-033 Reset, then Login, "Adm", 24'h000001 -> Usrname?, Passwd?, Ok, each with a single o_vld pulse one cycle after its word.
REQ-034 With no session, Buy -> InvalPerm; as user "Bob", AddItem -> InvalPerm; Login, "Zed" -> UsrUnknwn.
REQ-035 As admin, AddUsr five times with distinct names (default MAX_USERS) -> four Ok, fifth Full; DelUsr "Adm" -> NoDelAdmn; AddUsr of an existing name -> UsrTaken.
REQ-036 Admin AddItem "Pen" qty 250 then qty 10 -> stock 255 (saturated); as user, Buy "Pen" 256 (mod 2^8 = 0) -> Ok with no change; Buy 200 -> Ok, stock 55; Buy 56 -> NoStock.
REQ-037 With SHOP_DB_TIMEOUT_EN and TIMEOUT_CYC = 16: Login, then 16 idle cycles -> Timeout with state CMD; at 15 idle cycles plus a word, no Timeout.
REQ-038 Assert i_reset during QTY of Buy "Pen" 5 -> stock unchanged, no response, session none, only admin valid after release.
